// File: rtl/xor_accum_pkg.sv
// Shared types and constant helpers for the xor_accum checksum engine and its
// xor_reduce folding tree.
package xor_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } xor_accum_state_t;

    // Widest lane the mask helper can cover; callers cast down to their lane width.
    localparam int MASK_W = 1024;

    function automatic logic [MASK_W-1:0] keep_mask(input logic keep);
        return {MASK_W{keep}};
    endfunction

    // Number of xor3 levels needed to reduce n operands to one.
    function automatic int xor3_levels(input int n);
        int levels = 0;
        int width  = 1;
        while (width < n) begin
            width  = width * 3;
            levels = levels + 1;
        end
        return levels;
    endfunction

    function automatic int pow3(input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * 3;
        return r;
    endfunction

endpackage

// File: rtl/xor_reduce.sv
// Combinational INPUTS x BITS -> BITS XOR reduction with per-lane keep, built as
// a tree of xor3 cells with missing operands padded to zero.
module xor_reduce
    import xor_accum_pkg::*;
#(
    parameter int BITS   = 8,
    parameter int INPUTS = 3
) (
    input  logic [INPUTS*BITS-1:0] data_i,
    input  logic [INPUTS-1:0]      keep_i,
    output logic [BITS-1:0]        data_o
);

    localparam int LEVELS = xor3_levels(INPUTS);
    localparam int WIDTH  = pow3(LEVELS);

    always_comb begin : tree
        logic [BITS-1:0] node [WIDTH];
        // NOTE: blocking assignments here are deliberate; each level reads the
        // values the previous level just wrote within this same evaluation.
        for (int i = 0; i < WIDTH; i++) node[i] = '0;
        for (int i = 0; i < INPUTS; i++)
            node[i] = data_i[i*BITS +: BITS] & BITS'(keep_mask(keep_i[i]));
        // In-place tree: node[j] is rebuilt from node[3j..3j+2], which are never
        // overwritten earlier in the same level.
        for (int l = 0; l < LEVELS; l++)
            for (int j = 0; j < WIDTH / 3; j++)
                node[j] = node[3*j] ^ node[3*j+1] ^ node[3*j+2];
        data_o = node[0];
    end

endmodule

// File: rtl/xor_accum.sv
// Streaming per-frame XOR accumulator with valid/ready on both sides.
// Define XOR_ACCUM_COUNT_EN to add the saturating beat counter and out_beats port.
module xor_accum
    import xor_accum_pkg::*;
#(
    parameter int BITS     = 8,
    parameter int INPUTS   = 3
`ifdef XOR_ACCUM_COUNT_EN
    ,
    parameter int CNT_BITS = 16
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INPUTS*BITS-1:0] in_data,
    input  logic [INPUTS-1:0]      in_keep,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BITS-1:0]        out_data
`ifdef XOR_ACCUM_COUNT_EN
    ,
    output logic [CNT_BITS-1:0]    out_beats
`endif
);

    xor_accum_state_t state_q, state_d;
    logic [BITS-1:0]  acc_q, acc_d;
    logic [BITS-1:0]  out_data_q, out_data_d;
    logic [BITS-1:0]  fold;
    logic             accept;
    logic             drain;

    xor_reduce #(
        .BITS   (BITS),
        .INPUTS (INPUTS)
    ) u_reduce (
        .data_i (in_data),
        .keep_i (in_keep),
        .data_o (fold)
    );

    // In HOLD a new beat is only taken in the cycle the pending result drains.
    assign in_ready  = (state_q != HOLD) || out_ready;
    assign accept    = in_valid && in_ready;
    assign drain     = (state_q == HOLD) && out_ready;
    assign out_valid = (state_q == HOLD);
    assign out_data  = out_data_q;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        if (drain) state_d = IDLE;
        if (accept) begin
            if (in_last) begin
                state_d    = HOLD;
                out_data_d = acc_q ^ fold;
                acc_d      = '0;
            end else begin
                state_d = ACCUM;
                acc_d   = acc_q ^ fold;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
        end
    end

`ifdef XOR_ACCUM_COUNT_EN
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [CNT_BITS-1:0] beats_q, beats_d;
    logic [CNT_BITS-1:0] cnt_inc;

    // cnt_q holds beats already taken in the open frame; zero between frames.
    always_comb begin
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_BITS'(1);
        cnt_d   = cnt_q;
        beats_d = beats_q;
        if (accept) begin
            if (in_last) begin
                beats_d = cnt_inc;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            beats_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            beats_q <= beats_d;
        end
    end

    assign out_beats = beats_q;
`endif

`ifdef FORMAL
    a_stable_data: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid && !out_ready |=> $stable(out_data));
`ifdef XOR_ACCUM_COUNT_EN
    a_stable_beats: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid && !out_ready |=> $stable(out_beats));
`endif
    a_idle_acc_zero: assert property (@(posedge clk) disable iff (!rst_n)
        state_q == IDLE |-> acc_q == '0);
    a_valid_needs_last: assert property (@(posedge clk) disable iff (!rst_n)
        $rose(out_valid) |-> $past(accept && in_last));
`endif

endmodule
